video_frame_signature: RTL

//  Synthesizable pixel-stream monitor on the pixel_clk domain of the HDMI controller; replaces BMP dumping.

---
 rtl/video_frame_signature.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/video_frame_signature.sv
// -----------------------------------------------------------------------------
// video_frame_signature
//
// Pixel-stream monitor on the pixel_clk domain. Once armed, it waits for the
// start of a frame (vsync leading edge). It then folds FRAMES whole frames into
// a 32-bit rotate-XOR signature and counts active pixels and active lines.
// The results are published together with a one-cycle done pulse.
//
// Optional feature (compile-time macro COORD_CHECK_EN):
//   When defined, the monitor keeps its own expected x/y position. It flags any
//   active pixel whose drawX/drawY disagree with that position (coord_err).
//   When undefined, drawX/drawY are ignored and coord_err is tied low.
//
// Ports
//   pixel_clk   in   1        pixel clock
//   arstn       in   1        synchronous, active-low reset
//   arm         in   1        start request (honoured in IDLE or DONE only)
//   pixel_vde   in   1        active-video enable
//   pixel_vs    in   1        vertical sync (active level = VS_POL)
//   pixel_rgb   in   PIX_W    packed pixel word {ch[NUM_CH-1],...,ch[0]}
//   drawX       in   COORD_W  current column
//   drawY       in   COORD_W  current row
//   busy        out  1        waiting for vsync or capturing
//   done        out  1        one-cycle pulse when results update
//   frame_sig   out  32       signature of the last completed capture
//   pix_count   out  32       active-pixel cycles in the last capture
//   line_count  out  16       vde falling edges in the last capture
//   size_err    out  1        pix_count != FRAMES*H_ACTIVE*V_ACTIVE
//   coord_err   out  1        coordinate mismatch seen during the last capture
// -----------------------------------------------------------------------------
module video_frame_signature #(
    parameter int       NUM_CH   = 3,
    parameter int       CH_W     = 4,
    parameter int       H_ACTIVE = 640,
    parameter int       V_ACTIVE = 480,
    parameter int       COORD_W  = 10,
    parameter int       FRAMES   = 1,
    parameter logic     VS_POL   = 1'b0
) (
    input  logic                     pixel_clk,
    input  logic                     arstn,
    input  logic                     arm,
    input  logic                     pixel_vde,
    input  logic                     pixel_vs,
    input  logic [NUM_CH*CH_W-1:0]   pixel_rgb,
    input  logic [COORD_W-1:0]       drawX,
    input  logic [COORD_W-1:0]       drawY,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              frame_sig,
    output logic [31:0]              pix_count,
    output logic [15:0]              line_count,
    output logic                     size_err,
    output logic                     coord_err
);

    localparam logic [31:0] EXP_PIX  = 32'(FRAMES * H_ACTIVE * V_ACTIVE);
    localparam logic [7:0]  FRAMES_C = 8'(FRAMES);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_VS = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_vs_q;
    logic        r_vde_q;
    logic [31:0] r_sig_acc;
    logic [31:0] r_pix_acc;
    logic [15:0] r_line_acc;
    logic [7:0]  r_frm_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_frame_sig;
    logic [31:0] r_pix_count;
    logic [15:0] r_line_count;
    logic        r_size_err;

    logic        w_vs_edge;
    logic        w_line_end;
    logic [31:0] w_sig_next;
    logic [31:0] w_pix_next;
    logic [15:0] w_line_next;
    logic [7:0]  w_frm_next;
    logic        w_close;

    // Leading edge of vsync, seen in the same cycle the input changes.
    assign w_vs_edge  = (pixel_vs == VS_POL) && (r_vs_q != VS_POL);
    assign w_line_end = r_vde_q && !pixel_vde;

    // Next-value views of the accumulators. Using them when the capture closes
    // folds a pixel or line end that coincides with the closing vsync edge.
    assign w_sig_next  = pixel_vde ? ({r_sig_acc[30:0], r_sig_acc[31]} ^ 32'(pixel_rgb))
                                   : r_sig_acc;
    assign w_pix_next  = pixel_vde ? (r_pix_acc + 32'd1) : r_pix_acc;
    assign w_line_next = (w_line_end && (r_line_acc != 16'hFFFF)) ? (r_line_acc + 16'd1)
                                                                 : r_line_acc;
    assign w_frm_next  = r_frm_cnt + 8'd1;
    assign w_close     = (r_state == ST_CAPTURE) && w_vs_edge && (w_frm_next == FRAMES_C);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (arm)       w_state_next = ST_WAIT_VS;
            ST_WAIT_VS: if (w_vs_edge) w_state_next = ST_CAPTURE;
            ST_CAPTURE: if (w_close)   w_state_next = ST_DONE;
            default:    if (arm)       w_state_next = ST_WAIT_VS;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            r_state      <= ST_IDLE;
            r_vs_q       <= ~VS_POL;
            r_vde_q      <= 1'b0;
            r_sig_acc    <= 32'd0;
            r_pix_acc    <= 32'd0;
            r_line_acc   <= 16'd0;
            r_frm_cnt    <= 8'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_frame_sig  <= 32'd0;
            r_pix_count  <= 32'd0;
            r_line_count <= 16'd0;
            r_size_err   <= 1'b0;
        end else begin
            r_vs_q  <= pixel_vs;
            r_vde_q <= pixel_vde;
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_WAIT_VS) || (w_state_next == ST_CAPTURE);
            r_done  <= w_close;

            if (r_state == ST_WAIT_VS && w_vs_edge) begin
                r_sig_acc  <= 32'd0;
                r_pix_acc  <= 32'd0;
                r_line_acc <= 16'd0;
                r_frm_cnt  <= 8'd0;
            end else if (r_state == ST_CAPTURE) begin
                r_sig_acc  <= w_sig_next;
                r_pix_acc  <= w_pix_next;
                r_line_acc <= w_line_next;
                if (w_vs_edge) begin
                    r_frm_cnt <= w_frm_next;
                end
            end

            if (w_close) begin
                r_frame_sig  <= w_sig_next;
                r_pix_count  <= w_pix_next;
                r_line_count <= w_line_next;
                r_size_err   <= (w_pix_next != EXP_PIX);
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign frame_sig  = r_frame_sig;
    assign pix_count  = r_pix_count;
    assign line_count = r_line_count;
    assign size_err   = r_size_err;

`ifdef COORD_CHECK_EN
    localparam logic [COORD_W-1:0] ONE_C = COORD_W'(1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_coord_err_acc;
    logic               r_coord_err;
    logic               w_coord_bad;

    assign w_coord_bad = pixel_vde && ((drawX != r_x) || (drawY != r_y));

    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            r_x             <= '0;
            r_y             <= '0;
            r_coord_err_acc <= 1'b0;
            r_coord_err     <= 1'b0;
        end else begin
            if (r_state == ST_WAIT_VS && w_vs_edge) begin
                r_x             <= '0;
                r_y             <= '0;
                r_coord_err_acc <= 1'b0;
            end else if (r_state == ST_CAPTURE) begin
                if (w_coord_bad) begin
                    r_coord_err_acc <= 1'b1;
                end
                if (pixel_vde) begin
                    r_x <= r_x + ONE_C;
                end else if (w_line_end) begin
                    r_x <= '0;
                    r_y <= r_y + ONE_C;
                end
                // A new frame restarts the row count even if a line ends now.
                if (w_vs_edge) begin
                    r_y <= '0;
                end
            end
            if (w_close) begin
                r_coord_err <= r_coord_err_acc | w_coord_bad;
            end
        end
    end

    assign coord_err = r_coord_err;
`else
    logic w_unused_coords;
    assign w_unused_coords = ^{drawX, drawY};
    assign coord_err       = 1'b0;
`endif

endmodule
